// File: rtl/layer_pkg.sv
// rtl/layer_pkg.sv - shared state encoding and width helpers for layer_serializer
package layer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ser_state_t;

  // Element counter width; never collapses to zero bits.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/argmax_tracker.sv
// rtl/argmax_tracker.sv - running signed argmax over one serialized frame
module argmax_tracker
  import layer_pkg::*;
#(
  parameter int NN = 4,
  parameter int W  = 16
)(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_valid,
  input  logic signed [W-1:0]       i_data,
  input  logic [cnt_width(NN)-1:0]  i_idx,
  input  logic                      i_last,
  output logic [cnt_width(NN)-1:0]  o_max_idx,
  output logic                      o_max_valid
);

  localparam int CW = cnt_width(NN);

  logic signed [W-1:0] r_best;
  logic [CW-1:0]       r_best_idx;
  logic [CW-1:0]       r_max_idx;
  logic                r_max_valid;
  logic                w_take;
  logic [CW-1:0]       w_best_idx;

  // Strict greater-than keeps the lowest index on ties; index 0 restarts the search.
  assign w_take     = (i_idx == '0) || (i_data > r_best);
  assign w_best_idx = w_take ? i_idx : r_best_idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_best      <= '0;
      r_best_idx  <= '0;
      r_max_idx   <= '0;
      r_max_valid <= 1'b0;
    end else begin
      r_max_valid <= 1'b0;
      if (i_valid) begin
        if (w_take) begin
          r_best     <= i_data;
          r_best_idx <= i_idx;
        end
        if (i_last) begin
          r_max_idx   <= w_best_idx;
          r_max_valid <= 1'b1;
        end
      end
    end
  end

  assign o_max_idx   = r_max_idx;
  assign o_max_valid = r_max_valid;

endmodule

// File: rtl/layer_serializer.sv
// rtl/layer_serializer.sv - parallel neuron outputs to serial stream; LAYER_SER_ARGMAX_EN adds argmax
module layer_serializer
  import layer_pkg::*;
#(
  parameter int NN        = 4,
  parameter int dataWidth = 16
)(
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NN-1:0]             i_valid,
  input  logic [NN*dataWidth-1:0]   i_data,
  output logic                      o_valid,
  output logic [dataWidth-1:0]      o_data,
  output logic                      o_last,
  output logic                      o_busy,
  output logic                      o_overrun
`ifdef LAYER_SER_ARGMAX_EN
  ,
  output logic [cnt_width(NN)-1:0]  o_max_idx,
  output logic                      o_max_valid
`endif
);

  localparam int            CW       = cnt_width(NN);
  localparam logic [CW-1:0] LAST_IDX = CW'(NN - 1);

  ser_state_t           r_state;
  logic [CW-1:0]        r_cnt;
  logic [dataWidth-1:0] r_buf [NN];
  logic                 r_valid;
  logic [dataWidth-1:0] r_data;
  logic                 r_last;
  logic                 r_busy;
  logic                 r_overrun;

  logic                 w_at_last;
  logic                 w_capture;
  logic                 w_drop;
  logic [CW-1:0]        w_cnt_nxt;
  logic                 w_unused_valid;

  // Only lane 0 qualifies a frame; the remaining valid bits carry no meaning here.
  assign w_unused_valid = ^i_valid[NN-1:1];

  assign w_at_last = (r_state == ST_SEND) && (r_cnt == LAST_IDX);
  assign w_capture = i_valid[0] && ((r_state == ST_IDLE) || w_at_last);
  assign w_drop    = i_valid[0] && (r_state == ST_SEND) && !w_at_last;
  assign w_cnt_nxt = r_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_last    <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
      for (int k = 0; k < NN; k++) r_buf[k] <= '0;
    end else begin
      if (w_drop) r_overrun <= 1'b1;
      if (w_capture) begin
        for (int k = 0; k < NN; k++) r_buf[k] <= i_data[k*dataWidth +: dataWidth];
        r_state <= ST_SEND;
        r_cnt   <= '0;
        r_valid <= 1'b1;
        r_data  <= i_data[0 +: dataWidth];
        r_last  <= 1'b0;
        r_busy  <= 1'b1;
      end else if (r_state == ST_SEND) begin
        if (w_at_last) begin
          // r_data is left alone so the last element stays visible while idle.
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_valid <= 1'b0;
          r_last  <= 1'b0;
          r_busy  <= 1'b0;
        end else begin
          r_cnt  <= w_cnt_nxt;
          r_data <= r_buf[w_cnt_nxt];
          r_last <= (w_cnt_nxt == LAST_IDX);
        end
      end
    end
  end

  assign o_valid   = r_valid;
  assign o_data    = r_data;
  assign o_last    = r_last;
  assign o_busy    = r_busy;
  assign o_overrun = r_overrun;

`ifdef LAYER_SER_ARGMAX_EN
  argmax_tracker #(
    .NN (NN),
    .W  (dataWidth)
  ) u_argmax (
    .clk         (clk),
    .rst         (rst),
    .i_valid     (r_valid),
    .i_data      (r_data),
    .i_idx       (r_cnt),
    .i_last      (r_last),
    .o_max_idx   (o_max_idx),
    .o_max_valid (o_max_valid)
  );
`endif

endmodule

// File: tb/tb_layer_serializer.sv
// tb/tb_layer_serializer.sv - directed self-checking bench for layer_serializer
module tb_layer_serializer;

  localparam int NN = 4;
  localparam int DW = 16;

  logic               clk;
  logic               rst;
  logic [NN-1:0]      i_valid;
  logic [NN*DW-1:0]   i_data;
  logic               o_valid;
  logic [DW-1:0]      o_data;
  logic               o_last;
  logic               o_busy;
  logic               o_overrun;
`ifdef LAYER_SER_ARGMAX_EN
  logic [1:0]         o_max_idx;
  logic               o_max_valid;
`endif

  int n_vec;
  int n_err;

  layer_serializer #(
    .NN        (NN),
    .dataWidth (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (i_valid),
    .i_data    (i_data),
    .o_valid   (o_valid),
    .o_data    (o_data),
    .o_last    (o_last),
    .o_busy    (o_busy),
    .o_overrun (o_overrun)
`ifdef LAYER_SER_ARGMAX_EN
    ,
    .o_max_idx   (o_max_idx),
    .o_max_valid (o_max_valid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  localparam logic [NN*DW-1:0] FRAME_A = {16'd4, 16'd3, 16'd2, 16'd1};
  localparam logic [NN*DW-1:0] FRAME_B = {16'd8, 16'd7, 16'd6, 16'd5};

  initial begin
    n_vec   = 0;
    n_err   = 0;
    rst     = 1'b0;
    i_valid = '0;
    i_data  = '0;
    tick();
    tick();
    chk("rst_valid",   {31'd0, o_valid},   32'd0);
    chk("rst_data",    {16'd0, o_data},    32'd0);
    chk("rst_last",    {31'd0, o_last},    32'd0);
    chk("rst_busy",    {31'd0, o_busy},    32'd0);
    chk("rst_overrun", {31'd0, o_overrun}, 32'd0);
    rst = 1'b1;
    tick();

    // Single frame
    i_data  = FRAME_A;
    i_valid = 4'hF;
    chk("sf_pre_valid", {31'd0, o_valid}, 32'd0);
    tick();
    i_valid = '0;
    for (int k = 0; k < NN; k++) begin
      chk("sf_valid", {31'd0, o_valid}, 32'd1);
      chk("sf_data",  {16'd0, o_data},  32'(k + 1));
      chk("sf_last",  {31'd0, o_last},  (k == NN - 1) ? 32'd1 : 32'd0);
      chk("sf_busy",  {31'd0, o_busy},  32'd1);
      tick();
    end
    chk("sf_end_valid",   {31'd0, o_valid},   32'd0);
    chk("sf_hold_data",   {16'd0, o_data},    32'd4);
    chk("sf_end_busy",    {31'd0, o_busy},    32'd0);
    chk("sf_end_last",    {31'd0, o_last},    32'd0);
    chk("sf_overrun",     {31'd0, o_overrun}, 32'd0);

    // Partial valid: lane 0 low, no capture
    i_data  = FRAME_B;
    i_valid = 4'b1110;
    tick();
    chk("pv_valid", {31'd0, o_valid}, 32'd0);
    chk("pv_busy",  {31'd0, o_busy},  32'd0);
    tick();
    i_valid = '0;
    chk("pv_valid2", {31'd0, o_valid}, 32'd0);
    tick();

    // Back-to-back: second capture in the o_last cycle
    i_data  = FRAME_A;
    i_valid = 4'hF;
    tick();
    i_valid = '0;
    for (int k = 0; k < 2 * NN; k++) begin
      chk("bb_valid", {31'd0, o_valid}, 32'd1);
      chk("bb_data",  {16'd0, o_data},  32'(k + 1));
      chk("bb_last",  {31'd0, o_last},  ((k == 3) || (k == 7)) ? 32'd1 : 32'd0);
      if (k == 3) begin
        i_data  = FRAME_B;
        i_valid = 4'hF;
      end
      tick();
      i_valid = '0;
    end
    chk("bb_end_valid", {31'd0, o_valid},   32'd0);
    chk("bb_overrun",   {31'd0, o_overrun}, 32'd0);
    tick();

    // Overrun: capture in the second emit cycle is dropped
    i_data  = FRAME_A;
    i_valid = 4'hF;
    tick();
    i_valid = '0;
    chk("ov_d1", {16'd0, o_data}, 32'd1);
    tick();
    chk("ov_d2", {16'd0, o_data}, 32'd2);
    i_data  = FRAME_B;
    i_valid = 4'hF;
    tick();
    i_valid = '0;
    chk("ov_d3",       {16'd0, o_data},    32'd3);
    chk("ov_flag",     {31'd0, o_overrun}, 32'd1);
    tick();
    chk("ov_d4",       {16'd0, o_data},    32'd4);
    chk("ov_last",     {31'd0, o_last},    32'd1);
    tick();
    chk("ov_end",      {31'd0, o_valid},   32'd0);
    tick();
    tick();
    chk("ov_sticky",   {31'd0, o_overrun}, 32'd1);

    // Reset during the third emit cycle
    i_data  = FRAME_A;
    i_valid = 4'hF;
    tick();
    i_valid = '0;
    tick();
    tick();
    chk("rm_d3", {16'd0, o_data}, 32'd3);
    rst = 1'b0;
    #1;
    chk("rm_valid",   {31'd0, o_valid},   32'd0);
    chk("rm_data",    {16'd0, o_data},    32'd0);
    chk("rm_last",    {31'd0, o_last},    32'd0);
    chk("rm_busy",    {31'd0, o_busy},    32'd0);
    chk("rm_overrun", {31'd0, o_overrun}, 32'd0);
    tick();
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("rm_after_valid", {31'd0, o_valid}, 32'd0);
    end

`ifdef LAYER_SER_ARGMAX_EN
    // Argmax: {-5, 7, 7, 2} by index -> idx 1
    i_data  = {16'd2, 16'd7, 16'd7, 16'hFFFB};
    i_valid = 4'hF;
    tick();
    i_valid = '0;
    tick();
    tick();
    tick();
    chk("am_last",      {31'd0, o_last},      32'd1);
    chk("am_pre_valid", {31'd0, o_max_valid}, 32'd0);
    tick();
    chk("am_valid",     {31'd0, o_max_valid}, 32'd1);
    chk("am_idx",       {30'd0, o_max_idx},   32'd1);
    tick();
    chk("am_pulse",     {31'd0, o_max_valid}, 32'd0);
    chk("am_idx_hold",  {30'd0, o_max_idx},   32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/layer_serializer.md
LAYER_SERIALIZER -- requirements
Module: layer_serializer

Interface
REQ-001 SHALL have parameter NN, default 4, number of parallel neuron outputs accepted per frame (NN >= 2).
REQ-002 SHALL have parameter dataWidth, default 16, width of each neuron output, signed two's complement.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port i_valid  input  NN  per-neuron output valid from the preceding layer.
REQ-006 SHALL have port i_data  input  NN*dataWidth  packed neuron outputs; element k at bits [k*dataWidth +: dataWidth].
REQ-007 SHALL have port o_valid  output  1  serial element valid, driving the next layer's x_valid.
REQ-008 SHALL have port o_data  output  dataWidth  serial element, driving the next layer's x_in.
REQ-009 SHALL have port o_last  output  1  high with the element of index NN-1.
REQ-010 SHALL have port o_busy  output  1  high while a frame is being emitted.
REQ-011 SHALL have port o_overrun  output  1  sticky flag: a frame was dropped.

Function
REQ-012 SHALL sample the frame on i_valid[0] only; the other i_valid bits are ignored.
REQ-013 SHALL implement states IDLE and SEND; IDLE -> SEND on capture; SEND -> IDLE after element NN-1, unless a new capture occurs in that same cycle.
REQ-014 SHALL, on capture, register all NN elements into an internal buffer in the capture cycle.
REQ-015 SHALL assert o_valid for exactly NN consecutive cycles, starting the cycle after capture, emitting index 0 first and index NN-1 last.
REQ-016 SHALL hold o_data at its last value while o_valid is low.
REQ-017 SHALL keep o_busy high in every cycle of SEND.
REQ-018 SHALL accept a capture coinciding with emission of element NN-1, so that index 0 of the new frame follows with no gap cycle.
REQ-019 SHALL drop any capture during SEND other than the one in REQ-018, and set o_overrun; the buffer and element counter are unaffected.
REQ-020 SHALL use an element counter of width $clog2(NN) that wraps from NN-1 to 0.

Reset
REQ-021 SHALL, while rst is low, force state to IDLE, the counter to 0, and the buffer to 0.
REQ-022 SHALL, while rst is low, force o_valid, o_last, o_busy and o_overrun to 0 and o_data to 0.
REQ-023 SHALL abandon any frame in progress on reset, with no further o_valid after rst is released until a new capture.
REQ-024 SHALL clear o_overrun only by reset.

Configuration
REQ-025 SHALL compile an argmax tracker only when macro LAYER_SER_ARGMAX_EN is defined.
REQ-026 SHALL, with LAYER_SER_ARGMAX_EN defined, add output o_max_idx ($clog2(NN) bits) and output o_max_valid (1 bit).
REQ-027 SHALL, with LAYER_SER_ARGMAX_EN defined, compare elements as signed values and keep the lowest index on ties.
REQ-028 SHALL, with LAYER_SER_ARGMAX_EN defined, pulse o_max_valid for one cycle, the cycle after o_last, with o_max_idx valid and held until the next update.
REQ-029 SHALL, without LAYER_SER_ARGMAX_EN, omit both argmax ports and all argmax logic.

Structure
REQ-030 SHALL take state encoding (IDLE/SEND) and counter-width helper constants from a shared package, layer_pkg.
REQ-031 SHALL place the argmax tracker in a single sub-module, argmax_tracker, instantiated only under LAYER_SER_ARGMAX_EN.

Verification
REQ-032 SHALL cover single frame: NN=4, i_data {4,3,2,1} (index 0 = 1), i_valid=4'hF for one cycle -> o_valid high 4 cycles, o_data 1,2,3,4, o_last on 4, first o_valid one cycle after capture.
REQ-033 SHALL cover back-to-back: second capture in the o_last cycle -> 8 contiguous o_valid cycles, o_overrun=0.
REQ-034 SHALL cover overrun: capture in the 2nd emit cycle -> first frame completes unchanged, o_overrun=1 and stays 1 until reset.
REQ-035 SHALL cover reset mid-frame: rst low during the 3rd emit cycle -> all outputs 0 immediately, no o_valid after release.
REQ-036 SHALL cover argmax (macro defined): elements {-5,7,7,2} by index -> o_max_idx=1, o_max_valid one cycle after o_last.
REQ-037 SHALL cover partial valid: i_valid=4'b1110 -> no capture, o_valid stays 0.
